// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the store narrowing path.
//   size_e        : MEM-stage access size encoding (sb/sh/sw/reserved)
//   occ_e         : store-buffer occupancy classification
//   store_entry_t : one queued store {word address, byte enables, lane data}
package mips_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'b00,
    OCC_PARTIAL = 2'b01,
    OCC_FULL    = 2'b10
  } occ_e;

  // Address field width of a queued entry; the top-level ADDR_W must not
  // exceed it.
  localparam int ENTRY_ADDR_W = 32;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [3:0]              be;
    logic [31:0]             wdata;
  } store_entry_t;

endpackage

// File: rtl/store_lane_align.sv
// store_lane_align: combinational narrowing of a store operand onto
// little-endian byte lanes, byte-enable generation and misalignment detection.
// Optional feature macro: STORE_ALIGN_CHECK_EN (flags misaligned/reserved
// accesses; when undefined the low address bits are forced to alignment).
// Ports:
//   i_addr     : byte address
//   i_size     : access size (size_e encoding)
//   i_data     : store operand, low bits used for sb/sh
//   o_entry    : word address, byte enables and lane-replicated data
//   o_misalign : access is misaligned or uses the reserved size
module store_lane_align
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_size,
  input  logic [31:0]       i_data,
  output store_entry_t      o_entry,
  output logic              o_misalign
);

  logic [1:0] lane;
  assign lane = i_addr[1:0];

  always_comb begin
    o_entry.addr  = ENTRY_ADDR_W'({i_addr[ADDR_W-1:2], 2'b00});
    o_entry.be    = 4'b1111;
    o_entry.wdata = i_data;
    case (i_size)
      SIZE_B: begin
        o_entry.be    = 4'b0001 << lane;
        o_entry.wdata = {4{i_data[7:0]}};
      end
      SIZE_H: begin
        // Halfword lane is forced to 0 or 2; an odd address is either
        // flagged below or silently realigned.
        o_entry.be    = 4'b0011 << {lane[1], 1'b0};
        o_entry.wdata = {2{i_data[15:0]}};
      end
      // Word and reserved sizes write the full word.
      default: ;
    endcase
  end

`ifdef STORE_ALIGN_CHECK_EN
  always_comb begin
    o_misalign = 1'b0;
    case (i_size)
      SIZE_H:   o_misalign = lane[0];
      SIZE_W:   o_misalign = (lane != 2'b00);
      SIZE_RSV: o_misalign = 1'b1;
      default:  o_misalign = 1'b0;
    endcase
  end
`else
  assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/store_narrow_buffer.sv
// store_narrow_buffer: narrows MEM-stage stores to byte/halfword lanes and
// queues them in a DEPTH-entry FIFO drained to data memory via valid/ready.
// Optional feature macro: STORE_ALIGN_CHECK_EN (misaligned or reserved-size
// stores complete the handshake, are dropped, and pulse o_misalign).
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_valid / o_ready   : store request handshake from MEM stage
//   i_addr/i_size/i_data: store byte address, size, operand
//   o_mem_valid / i_mem_ready : head-entry handshake to data memory
//   o_mem_addr/be/wdata : head entry (all zero while the buffer is empty)
//   o_busy              : buffer non-empty
//   o_misalign          : registered one-cycle misalignment pulse
module store_narrow_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_size,
  input  logic [31:0]       i_data,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  output logic              o_busy,
  output logic              o_misalign
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misalign_q, misalign_d;
  store_entry_t     mem_q [DEPTH];
  store_entry_t     new_entry, head;
  logic             lane_mis, push, enq, pop;
  occ_e             occ;

  store_lane_align #(.ADDR_W(ADDR_W)) u_align (
    .i_addr     (i_addr),
    .i_size     (i_size),
    .i_data     (i_data),
    .o_entry    (new_entry),
    .o_misalign (lane_mis)
  );

  always_comb begin
    occ = OCC_EMPTY;
    if (count_q == CNT_W'(DEPTH)) occ = OCC_FULL;
    else if (count_q != '0)       occ = OCC_PARTIAL;
  end

  // No pass-through: a full buffer refuses even when the head pops.
  assign o_ready     = (occ != OCC_FULL) && !i_rst;
  assign o_mem_valid = (occ != OCC_EMPTY);
  assign o_busy      = o_mem_valid;

  // A flagged store still completes the handshake but is never queued.
  assign push = i_valid && o_ready;
  assign enq  = push && !lane_mis;
  assign pop  = o_mem_valid && i_mem_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    misalign_d = push && lane_mis;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Entry storage carries no reset; outputs are gated by o_mem_valid instead.
  always_ff @(posedge i_clk) begin
    if (enq) mem_q[wr_ptr_q] <= new_entry;
  end

  assign head        = mem_q[rd_ptr_q];
  assign o_mem_addr  = o_mem_valid ? ADDR_W'(head.addr) : '0;
  assign o_mem_be    = o_mem_valid ? head.be            : '0;
  assign o_mem_wdata = o_mem_valid ? head.wdata         : '0;
  assign o_misalign  = misalign_q;

endmodule

// File: tb/tb_store_narrow_buffer.sv
module tb_store_narrow_buffer;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 32;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_mem_ready;
  logic [31:0] i_addr, i_data;
  logic [1:0]  i_size;
  logic        o_ready, o_mem_valid, o_busy, o_misalign;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;

  always #5 i_clk = ~i_clk;

  store_narrow_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_addr      (i_addr),
    .i_size      (i_size),
    .i_data      (i_data),
    .o_mem_valid (o_mem_valid),
    .i_mem_ready (i_mem_ready),
    .o_mem_addr  (o_mem_addr),
    .o_mem_be    (o_mem_be),
    .o_mem_wdata (o_mem_wdata),
    .o_busy      (o_busy),
    .o_misalign  (o_misalign)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  sz;
    logic [31:0] d;
    logic [31:0] ea;
    logic [3:0]  ebe;
    logic [31:0] ewd;
  } vec_t;

  exp_t q[$];
  logic mis_q;
  logic cur_rst;
  int   checks   = 0;
  int   failures = 0;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: expected memory request from the lane rules, using arithmetic.
  function automatic exp_t model_entry(input logic [31:0] a, input logic [1:0] sz,
                                       input logic [31:0] d);
    exp_t        e;
    int unsigned k;
    k      = a % 4;
    e.addr = a - k;
    case (sz)
      2'd0: begin
        e.be    = 4'(1 << k);
        e.wdata = (d & 32'hFF) * 32'h0101_0101;
      end
      2'd1: begin
        k       = (k >= 2) ? 2 : 0;
        e.be    = 4'(3 << k);
        e.wdata = (d & 32'hFFFF) * 32'h0001_0001;
      end
      default: begin
        e.be    = 4'hF;
        e.wdata = d;
      end
    endcase
    return e;
  endfunction

  function automatic logic model_mis(input logic [31:0] a, input logic [1:0] sz);
`ifdef STORE_ALIGN_CHECK_EN
    return (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0) || (sz == 2'd3);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs();
    exp_t h;
    logic ev;
    ev = (q.size() > 0);
    h  = '{32'h0, 4'h0, 32'h0};
    if (ev) h = q[0];
    check("mem_valid", 32'(o_mem_valid), 32'(ev));
    check("busy", 32'(o_busy), 32'(ev));
    check("ready", 32'(o_ready), 32'(!cur_rst && q.size() < DEPTH));
    check("misalign", 32'(o_misalign), 32'(mis_q));
    check("mem_addr", o_mem_addr, h.addr);
    check("mem_be", 32'(o_mem_be), 32'(h.be));
    check("mem_wdata", o_mem_wdata, h.wdata);
  endtask

  // Called at a negedge: check current outputs, drive the next inputs,
  // advance the model across the coming posedge, then wait for the next negedge.
  task automatic step(input logic rst, input logic v, input logic [31:0] a,
                      input logic [1:0] sz, input logic [31:0] d, input logic mr);
    logic acc, pp, mis;
    exp_t e;
    check_outputs();
    i_rst = rst; i_valid = v; i_addr = a; i_size = sz; i_data = d; i_mem_ready = mr;
    cur_rst = rst;
    if (rst) begin
      q.delete();
      mis_q = 1'b0;
    end else begin
      acc = v && (q.size() < DEPTH);
      pp  = (q.size() > 0) && mr;
      mis = model_mis(a, sz);
      e   = model_entry(a, sz, d);
      if (pp) void'(q.pop_front());
      if (acc && !mis) q.push_back(e);
      mis_q = acc && mis;
    end
    @(negedge i_clk);
  endtask

  task automatic idle(input logic mr);
    step(1'b0, 1'b0, 32'h0, 2'd0, 32'h0, mr);
  endtask

  initial begin
    tbl[0] = '{32'h0000_0103, 2'd0, 32'h1234_5678, 32'h0000_0100, 4'b1000, 32'h7878_7878};
    tbl[1] = '{32'h0000_0202, 2'd1, 32'hAAAA_BEEF, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF};
    tbl[2] = '{32'h0000_0300, 2'd2, 32'hDEAD_BEEF, 32'h0000_0300, 4'b1111, 32'hDEAD_BEEF};
    tbl[3] = '{32'h0000_0100, 2'd0, 32'hCAFE_00A5, 32'h0000_0100, 4'b0001, 32'hA5A5_A5A5};
    tbl[4] = '{32'h0000_0201, 2'd0, 32'h0000_003C, 32'h0000_0200, 4'b0010, 32'h3C3C_3C3C};
    tbl[5] = '{32'h0000_0400, 2'd1, 32'h1234_ABCD, 32'h0000_0400, 4'b0011, 32'hABCD_ABCD};
    tbl[6] = '{32'hFFFF_FFFE, 2'd0, 32'h0000_0055, 32'hFFFF_FFFC, 4'b0100, 32'h5555_5555};

    i_rst = 1'b1; i_valid = 1'b0; i_addr = '0; i_size = '0; i_data = '0; i_mem_ready = 1'b0;
    cur_rst = 1'b1; mis_q = 1'b0;
    @(negedge i_clk);

    // Reset state, held while i_rst is high.
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_valid", 32'(o_mem_valid), 32'd0);
    check("rst_be", 32'(o_mem_be), 32'd0);
    step(1'b1, 1'b1, 32'h0, 2'd2, 32'h0, 1'b0);
    idle(1'b0);
    check("ready_after_rst", 32'(o_ready), 32'd1);

    // Directed lane vectors.
    foreach (tbl[i]) begin
      step(1'b0, 1'b1, tbl[i].a, tbl[i].sz, tbl[i].d, 1'b0);
      check("vec_valid", 32'(o_mem_valid), 32'd1);
      check("vec_addr", o_mem_addr, tbl[i].ea);
      check("vec_be", 32'(o_mem_be), 32'(tbl[i].ebe));
      check("vec_wdata", o_mem_wdata, tbl[i].ewd);
      idle(1'b1);
    end

    // Misaligned word.
    step(1'b0, 1'b1, 32'h0000_0102, 2'd2, 32'h1122_3344, 1'b0);
`ifdef STORE_ALIGN_CHECK_EN
    check("mis_pulse", 32'(o_misalign), 32'd1);
    check("mis_noenq", 32'(o_mem_valid), 32'd0);
    idle(1'b1);
    check("mis_clear", 32'(o_misalign), 32'd0);
`else
    check("realign_addr", o_mem_addr, 32'h0000_0100);
    check("realign_be", 32'(o_mem_be), 32'hF);
    idle(1'b1);
`endif
    step(1'b0, 1'b1, 32'h0000_0101, 2'd1, 32'h0000_7E57, 1'b0);
    idle(1'b1);
    step(1'b0, 1'b1, 32'h0000_0207, 2'd3, 32'h0BAD_F00D, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Fill with memory stalled; outputs must hold.
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, 32'h1000 + 32'(i * 4), 2'd2, 32'hA000_0000 + 32'(i), 1'b0);
    check("full_ready", 32'(o_ready), 32'd0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h2000, 2'd2, 32'hFFFF_FFFF, 1'b0);
    // Full and popping: the new store is still refused.
    step(1'b0, 1'b1, 32'h2004, 2'd2, 32'hEEEE_EEEE, 1'b1);
    // Streaming at one store per cycle across several pointer wraps.
    for (int i = 0; i < 3 * DEPTH; i++)
      step(1'b0, 1'b1, 32'h3000 + 32'(i), 2'(i % 3), 32'hB000_0000 + 32'(i * 17), 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

    // Simultaneous push/pop at count 1.
    step(1'b0, 1'b1, 32'h4000, 2'd2, 32'h0000_0001, 1'b0);
    step(1'b0, 1'b1, 32'h4004, 2'd2, 32'h0000_0002, 1'b1);
    check("pp_busy", 32'(o_busy), 32'd1);
    check("pp_head", o_mem_wdata, 32'h0000_0002);
    idle(1'b1);
    check("pp_empty", 32'(o_busy), 32'd0);

    // Reset with two entries queued.
    step(1'b0, 1'b1, 32'h5000, 2'd2, 32'h0000_0005, 1'b0);
    step(1'b0, 1'b1, 32'h5004, 2'd2, 32'h0000_0006, 1'b0);
    step(1'b1, 1'b0, 32'h0, 2'd0, 32'h0, 1'b1);
    check("rst_mid_valid", 32'(o_mem_valid), 32'd0);
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    idle(1'b0);
    step(1'b0, 1'b1, 32'h6001, 2'd0, 32'h0000_00C3, 1'b0);
    step(1'b0, 1'b1, 32'h6002, 2'd1, 32'h0000_9876, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), $urandom,
           2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 4) < 3));
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
